// File: rtl/spike_train_decoder.sv
// Hysteretic spike detector on a signed membrane-potential stream, with
// inter-spike interval measurement, saturating spike count and burst/silence flags.
module spike_train_decoder #(
  parameter int                          SAMPLE_W  = 8,
  parameter int                          ISI_W     = 16,
  parameter logic signed [SAMPLE_W-1:0]  THRESH_HI = 8'sd32,
  parameter logic signed [SAMPLE_W-1:0]  THRESH_LO = 8'sd0,
  parameter int                          BURST_ISI = 8,
  parameter int                          BURST_N   = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic signed [SAMPLE_W-1:0] sample_in,
  input  logic                       sample_valid,
  input  logic                       clear_stats,
  output logic                       spike,
  output logic [ISI_W-1:0]           isi,
  output logic                       isi_valid,
  output logic [15:0]                spike_count,
  output logic                       burst,
  output logic                       silent
);

  typedef enum logic {ARMED, FIRED} state_t;

  localparam logic [ISI_W:0] BURST_LIM = (ISI_W+1)'(BURST_ISI);
  localparam logic [3:0]     RUN_TH    = 4'(BURST_N-1);

  state_t             state, state_n;
  logic               first_seen, first_seen_n;
  logic [ISI_W-1:0]   cnt, cnt_n;
  logic [3:0]         run, run_n;
  logic               spike_n, isi_valid_n, burst_n, silent_n;
  logic [ISI_W-1:0]   isi_n;
  logic [15:0]        count_n;

  // Statistics as seen after a same-cycle clear; the sample is applied on top.
  logic               fs_c, silent_c;
  logic [ISI_W-1:0]   cnt_c, cnt_sat;
  logic [ISI_W:0]     cnt_p1;
  logic [3:0]         run_c, run_inc;
  logic [15:0]        count_c, count_inc;
  logic               fire, rearm;

  assign fs_c      = first_seen & ~clear_stats;
  assign silent_c  = silent & ~clear_stats;
  assign cnt_c     = clear_stats ? '0 : cnt;
  assign run_c     = clear_stats ? '0 : run;
  assign count_c   = clear_stats ? '0 : spike_count;
  assign cnt_p1    = {1'b0, cnt_c} + (ISI_W+1)'(1);
  assign cnt_sat   = cnt_p1[ISI_W] ? '1 : cnt_p1[ISI_W-1:0];
  assign run_inc   = (run_c == 4'hF) ? 4'hF : run_c + 4'd1;
  assign count_inc = (&count_c) ? count_c : count_c + 16'd1;

  assign fire  = sample_valid && (state == ARMED) && (sample_in > THRESH_HI);
  assign rearm = sample_valid && (state == FIRED) && (sample_in < THRESH_LO);

  always_ff @(posedge clk) begin
    if (rst) state <= ARMED;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    if (fire)       state_n = FIRED;
    else if (rearm) state_n = ARMED;
  end

  always_comb begin
    first_seen_n = fs_c;
    cnt_n        = cnt_c;
    run_n        = run_c;
    count_n      = count_c;
    silent_n     = silent_c;
    spike_n      = 1'b0;
    isi_valid_n  = 1'b0;
    isi_n        = isi;
    if (fire) begin
      spike_n      = 1'b1;
      first_seen_n = 1'b1;
      cnt_n        = '0;
      silent_n     = 1'b0;
      count_n      = count_inc;
      if (fs_c) begin
        isi_valid_n = 1'b1;
        isi_n       = cnt_sat;
        run_n       = ({1'b0, cnt_sat} <= BURST_LIM) ? run_inc : 4'd0;
      end
    end else if (sample_valid) begin
      cnt_n = cnt_sat;
      if (fs_c && (&cnt_sat)) silent_n = 1'b1;
      // Drop the burst as soon as the pending interval can no longer qualify.
      if ({1'b0, cnt_sat} >= BURST_LIM) run_n = 4'd0;
    end
    burst_n = (run_n >= RUN_TH);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      first_seen  <= 1'b0;
      cnt         <= '0;
      run         <= '0;
      spike       <= 1'b0;
      isi         <= '0;
      isi_valid   <= 1'b0;
      spike_count <= '0;
      burst       <= 1'b0;
      silent      <= 1'b0;
    end else begin
      first_seen  <= first_seen_n;
      cnt         <= cnt_n;
      run         <= run_n;
      spike       <= spike_n;
      isi         <= isi_n;
      isi_valid   <= isi_valid_n;
      spike_count <= count_n;
      burst       <= burst_n;
      silent      <= silent_n;
    end
  end

endmodule

// File: doc/spike_train_decoder.md
Name: spike_train_decoder

Overview:
- Receive-side companion to the neuron core: consumes the 8-bit signed membrane-potential stream the neuron emits and turns it into spike events.
- Detects spikes with a hysteretic threshold.
- Measures inter-spike interval (ISI) in samples, counts spikes, and flags bursting.
- Sits downstream of the neuron output, on the same clock. Its results feed the characterisation and debug logic.

Parameters:
- SAMPLE_W, 8: sample width. Signed two's complement, 2 integer bits + 6 fraction bits (the neuron's output format).
- ISI_W, 16: width of the ISI counter and isi output.
- THRESH_HI, 8'sd32 (+0.5): spike is detected when sample > THRESH_HI (signed).
- THRESH_LO, 8'sd0 (0.0): detector re-arms when sample < THRESH_LO (signed). Must be < THRESH_HI.
- BURST_ISI, 16'd8: an ISI <= BURST_ISI counts as an intra-burst interval.
- BURST_N, 3: number of consecutive closely spaced spikes needed to assert burst. Legal range 2..15.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- sample_in  in  SAMPLE_W  signed membrane-potential sample.
- sample_valid  in  1  sample_in is valid this cycle.
- clear_stats  in  1  synchronous clear of statistics.
- spike  out  1  one-cycle pulse per detected spike.
- isi  out  ISI_W  last measured inter-spike interval, in valid samples.
- isi_valid  out  1  one-cycle pulse when isi is updated.
- spike_count  out  16  saturating spike total.
- burst  out  1  level; neuron is currently bursting.
- silent  out  1  level; ISI counter has saturated since the last spike.

Behaviour:
- Reset (rst=1 at a clock edge):
  - Outputs: spike=0, isi=0, isi_valid=0, spike_count=0, burst=0, silent=0.
  - Internal: detector state=ARMED, first_seen=0, cnt=0, run=0.
  - Reset overrides all other inputs, including a mid-spike sample.
- Sample gating: only cycles with sample_valid=1 advance the FSM, cnt, or run. Invalid cycles hold all state; spike and isi_valid are 0 on those cycles.
- Latency: every output is registered. Results for a valid sample appear 1 cycle after it.
- Detector FSM (signed compares):
  - ARMED: sample > THRESH_HI -> spike event, go to FIRED. Otherwise stay.
  - FIRED: sample < THRESH_LO -> ARMED. THRESH_LO <= sample <= THRESH_HI, or above -> stay, with no new spike.
  - A sample exactly equal to THRESH_HI does not fire. A sample exactly equal to THRESH_LO does not re-arm.
- ISI measurement:
  - cnt is cleared to 0 on a spike sample.
  - On every other valid sample, cnt increments, saturating at 2^ISI_W-1.
  - On a spike sample with first_seen=1: isi = min(cnt+1, 2^ISI_W-1) and isi_valid pulses. Example: spikes on valid samples #0 and #5 give isi=5.
  - On the first spike after reset or clear: no isi_valid; first_seen becomes 1.
- silent:
  - Set when cnt reaches 2^ISI_W-1 while first_seen=1.
  - Cleared on the next spike.
- spike_count: increments on each spike event, saturating at 16'hFFFF.
- Burst tracking:
  - On a reported ISI <= BURST_ISI: run = min(run+1, 15).
  - On a reported ISI > BURST_ISI: run = 0.
  - burst = (run >= BURST_N-1).
  - If cnt+1 exceeds BURST_ISI before the next spike, run=0 and burst drops on that sample's output cycle. Burst does not wait for the next spike.
- clear_stats (any cycle, independent of sample_valid):
  - Clears spike_count, run, burst, silent, first_seen and cnt.
  - FSM state is kept, so a clear during FIRED does not re-fire.
  - If clear_stats coincides with a spike sample: the clear applies first, then the spike. Result: spike pulse emitted, spike_count=1, first_seen=1, cnt=0, no isi_valid.
- Simultaneous spike and saturation: the spike wins. cnt=0, silent=0, and isi reports the saturated value.

Test Plan:
- Reset, then 4 valid samples of -45 (~-0.7): spike=0, spike_count=0, isi_valid never pulses, all outputs 0.
- Valid sample sequence -40,40,40,-10,-40,40 (sample #0..#5, THRESH defaults): spike pulses 1 cycle after #1 and after #5. isi=4 with isi_valid on the second spike only; spike_count=2.
- Sample exactly 32 while ARMED -> no spike. Sample 0 while FIRED -> stays FIRED, and the next 40 does not fire.
- Spikes every 3 samples: burst=1 after the 3rd spike. Then no spike for 9 samples: burst drops on the 8th sample after the last spike (cnt+1=9 > 8).
- ISI_W=4 override, spike then 20 samples below THRESH_LO: silent=1 from sample 15. The next spike reports isi=15 and clears silent.
- clear_stats asserted on the same cycle as a spike sample with spike_count=7: spike pulses, spike_count=1, no isi_valid. The following spike 6 samples later gives isi=6.
